// File: rtl/pulse_cmd_pkg.sv
// Shared definitions for the pulse command decoder.
// Holds the opcode map, response bytes, flag bit positions, the FSM state
// type and the opcode -> payload length lookup.
package pulse_cmd_pkg;

   localparam logic [7:0] OP_PER      = 8'h01;
   localparam logic [7:0] OP_P1WID    = 8'h02;
   localparam logic [7:0] OP_DEL      = 8'h03;
   localparam logic [7:0] OP_P2WID    = 8'h04;
   localparam logic [7:0] OP_CP       = 8'h05;
   localparam logic [7:0] OP_P_BL     = 8'h06;
   localparam logic [7:0] OP_P_BL_OFF = 8'h07;
   localparam logic [7:0] OP_FLAGS    = 8'h08;
   localparam logic [7:0] OP_COMMIT   = 8'h10;

   localparam logic [7:0] RESP_ACK = 8'h06;
   localparam logic [7:0] RESP_NAK = 8'h15;

   localparam int FLAG_PU = 0;
   localparam int FLAG_BL = 1;

   typedef enum logic {ST_IDLE, ST_PAYLOAD} state_t;

   // Payload bytes that follow an opcode. Zero means "no payload", which
   // covers both COMMIT and unknown opcodes; the caller tells them apart.
   function automatic logic [2:0] payload_len(input logic [7:0] op);
      case (op)
         OP_PER, OP_P1WID, OP_DEL, OP_P2WID: payload_len = 3'd4;
         OP_CP, OP_P_BL, OP_FLAGS:           payload_len = 3'd1;
         OP_P_BL_OFF:                        payload_len = 3'd2;
         default:                            payload_len = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/param_bank.sv
// Staging and active parameter registers.
// Ports: clk/resetn (sync, active low); wr_en/wr_sel/wr_data write one
// staging field selected by opcode (low bits of wr_data); commit_req copies
// every staging field into the active outputs on one edge and raises the
// one-cycle commit strobe alongside.
module param_bank
   import pulse_cmd_pkg::*;
#(
   parameter logic [31:0] PER_RST   = 32'd201000,
   parameter logic [31:0] P1WID_RST = 32'd30,
   parameter logic [31:0] DEL_RST   = 32'd200,
   parameter logic [31:0] P2WID_RST = 32'd60
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wr_en,
   input  logic [7:0]  wr_sel,
   input  logic [31:0] wr_data,
   input  logic        commit_req,
   output logic [31:0] per,
   output logic [31:0] p1wid,
   output logic [31:0] del,
   output logic [31:0] p2wid,
   output logic [7:0]  cp,
   output logic [7:0]  p_bl,
   output logic [15:0] p_bl_off,
   output logic        pu,
   output logic        bl,
   output logic        commit
);

   logic [31:0] s_per, s_p1wid, s_del, s_p2wid;
   logic [7:0]  s_cp, s_p_bl;
   logic [15:0] s_p_bl_off;
   logic        s_pu, s_bl;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s_per <= PER_RST;   s_p1wid <= P1WID_RST;
         s_del <= DEL_RST;   s_p2wid <= P2WID_RST;
         s_cp  <= '0;        s_p_bl  <= '0;
         s_p_bl_off <= '0;   s_pu <= 1'b0;  s_bl <= 1'b0;
         per <= PER_RST;     p1wid <= P1WID_RST;
         del <= DEL_RST;     p2wid <= P2WID_RST;
         cp  <= '0;          p_bl  <= '0;
         p_bl_off <= '0;     pu <= 1'b0;    bl <= 1'b0;
         commit <= 1'b0;
      end else begin
         commit <= commit_req;
         if (wr_en) begin
            case (wr_sel)
               OP_PER:      s_per      <= wr_data;
               OP_P1WID:    s_p1wid    <= wr_data;
               OP_DEL:      s_del      <= wr_data;
               OP_P2WID:    s_p2wid    <= wr_data;
               OP_CP:       s_cp       <= wr_data[7:0];
               OP_P_BL:     s_p_bl     <= wr_data[7:0];
               OP_P_BL_OFF: s_p_bl_off <= wr_data[15:0];
               OP_FLAGS: begin
                  s_pu <= wr_data[FLAG_PU];
                  s_bl <= wr_data[FLAG_BL];
               end
               default: ;
            endcase
         end
         // Whole set moves together so the pulse stage never sees a mix.
         if (commit_req) begin
            per <= s_per;    p1wid <= s_p1wid;
            del <= s_del;    p2wid <= s_p2wid;
            cp  <= s_cp;     p_bl  <= s_p_bl;
            p_bl_off <= s_p_bl_off;
            pu <= s_pu;      bl <= s_bl;
         end
      end
   end

endmodule

// File: rtl/pulse_cmd_decoder.sv
// Byte-stream command decoder feeding the pulse generator.
// Ports: clk/resetn (sync, active low); rx_data/rx_valid byte strobe from
// the UART receiver; tx_data/tx_valid/tx_ready one-entry ACK/NAK response
// toward the UART transmitter; per..bl active parameters with commit strobe;
// err_cnt saturating count of NAKs, timeouts and overwritten responses.
module pulse_cmd_decoder
   import pulse_cmd_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 120000,
   parameter logic [31:0] PER_RST        = 32'd201000,
   parameter logic [31:0] P1WID_RST      = 32'd30,
   parameter logic [31:0] DEL_RST        = 32'd200,
   parameter logic [31:0] P2WID_RST      = 32'd60
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] per,
   output logic [31:0] p1wid,
   output logic [31:0] del,
   output logic [31:0] p2wid,
   output logic [7:0]  cp,
   output logic [7:0]  p_bl,
   output logic [15:0] p_bl_off,
   output logic        pu,
   output logic        bl,
   output logic        commit,
   output logic [7:0]  err_cnt
);

   localparam int GW = $clog2(TIMEOUT_CYCLES);
   localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [23:0]    asm_q, asm_d;
   logic [7:0]     sel_q, sel_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic           wr_en, commit_req, resp_new;
   logic [7:0]     resp_byte;
   logic [1:0]     err_inc;
   logic [8:0]     err_sum;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      asm_d      = asm_q;
      sel_d      = sel_q;
      gap_d      = gap_q;
      wr_en      = 1'b0;
      commit_req = 1'b0;
      resp_new   = 1'b0;
      resp_byte  = RESP_ACK;
      err_inc    = 2'd0;
      case (state_q)
         ST_IDLE: begin
            gap_d = '0;
            if (rx_valid) begin
               if (rx_data == OP_COMMIT) begin
                  commit_req = 1'b1;
                  resp_new   = 1'b1;
               end else if (payload_len(rx_data) != 3'd0) begin
                  state_d = ST_PAYLOAD;
                  cnt_d   = 2'(payload_len(rx_data) - 3'd1);
                  sel_d   = rx_data;
                  asm_d   = '0;
               end else begin
                  resp_new  = 1'b1;
                  resp_byte = RESP_NAK;
                  err_inc   = 2'd1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (rx_valid) begin
               gap_d = '0;
               asm_d = {asm_q[15:0], rx_data};
               if (cnt_q == 2'd0) begin
                  wr_en    = 1'b1;
                  resp_new = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end else if (gap_q == GAP_LAST) begin
               // Silent abort: staging untouched, no response byte.
               state_d = ST_IDLE;
               err_inc = 2'd1;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Response still pending (not taken this cycle) gets clobbered.
      if (resp_new && tx_valid && !tx_ready) err_inc = err_inc + 2'd1;
   end

   assign err_sum = {1'b0, err_cnt} + {7'b0, err_inc};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         asm_q    <= '0;
         sel_q    <= '0;
         gap_q    <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         err_cnt  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         sel_q   <= sel_d;
         gap_q   <= gap_d;
         err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
         if (resp_new) begin
            tx_valid <= 1'b1;
            tx_data  <= resp_byte;
         end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

   // Final payload byte is folded in combinationally so the staging write
   // lands on the edge that samples it.
   param_bank #(
      .PER_RST(PER_RST), .P1WID_RST(P1WID_RST),
      .DEL_RST(DEL_RST), .P2WID_RST(P2WID_RST)
   ) u_bank (
      .clk        (clk),
      .resetn     (resetn),
      .wr_en      (wr_en),
      .wr_sel     (sel_q),
      .wr_data    ({asm_q, rx_data}),
      .commit_req (commit_req),
      .per        (per),
      .p1wid      (p1wid),
      .del        (del),
      .p2wid      (p2wid),
      .cp         (cp),
      .p_bl       (p_bl),
      .p_bl_off   (p_bl_off),
      .pu         (pu),
      .bl         (bl),
      .commit     (commit)
   );

endmodule

// File: tb/tb_pulse_cmd_decoder.sv
// Testbench for pulse_cmd_decoder: byte-frame reference model, per-cycle
// compare against it, directed scenarios with literal expectations, then
// a randomized byte stream.
module tb_pulse_cmd_decoder;

   localparam int T = 64;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic [31:0] per, p1wid, del, p2wid;
   logic [7:0]  cp, p_bl, err_cnt;
   logic [15:0] p_bl_off;
   logic        pu, bl, commit;

   pulse_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .cp(cp),
      .p_bl(p_bl), .p_bl_off(p_bl_off), .pu(pu), .bl(bl),
      .commit(commit), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // ---------------- reference model ----------------
   logic [31:0] stg [1:8];
   logic [31:0] act [1:8];
   logic [7:0]  frame [$];
   int          idle;
   logic        m_commit, m_txv;
   logic [7:0]  m_txd;
   int          m_err;

   function automatic int len_of(input logic [7:0] op);
      case (op)
         8'h01, 8'h02, 8'h03, 8'h04: return 4;
         8'h05, 8'h06, 8'h08:        return 1;
         8'h07:                      return 2;
         default:                    return 0;
      endcase
   endfunction

   function automatic logic [31:0] dflt(input int i);
      case (i)
         1: return 32'd201000;
         2: return 32'd30;
         3: return 32'd200;
         4: return 32'd60;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 1; i <= 8; i++) begin
         stg[i] = dflt(i);
         act[i] = dflt(i);
      end
      frame.delete();
      idle = 0; m_commit = 1'b0; m_txv = 1'b0; m_txd = 8'h00; m_err = 0;
   endtask

   task automatic bump_err();
      if (m_err < 255) m_err++;
   endtask

   initial model_reset();

   always @(posedge clk) begin : model
      bit          resp;
      logic [7:0]  rb;
      logic [31:0] v;
      if (!resetn) begin
         model_reset();
      end else begin
         resp = 1'b0; rb = 8'h06; m_commit = 1'b0;
         if (frame.size() == 0) begin
            if (rx_valid) begin
               if (rx_data == 8'h10) begin
                  act = stg; m_commit = 1'b1; resp = 1'b1;
               end else if (len_of(rx_data) > 0) begin
                  frame.push_back(rx_data); idle = 0;
               end else begin
                  resp = 1'b1; rb = 8'h15; bump_err();
               end
            end
         end else if (rx_valid) begin
            frame.push_back(rx_data); idle = 0;
            if (frame.size() == len_of(frame[0]) + 1) begin
               v = 32'd0;
               for (int i = 1; i < frame.size(); i++) v = (v << 8) | 32'(frame[i]);
               stg[frame[0]] = v;
               resp = 1'b1;
               frame.delete();
            end
         end else begin
            idle++;
            if (idle == T) begin
               frame.delete();
               bump_err();
            end
         end
         if (resp) begin
            if (m_txv && !tx_ready) bump_err();
            m_txv = 1'b1; m_txd = rb;
         end else if (m_txv && tx_ready) begin
            m_txv = 1'b0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", n, $time, a, e);
      end
   endtask

   always @(negedge clk) begin : compare
      chk("per",      per,             act[1]);
      chk("p1wid",    p1wid,           act[2]);
      chk("del",      del,             act[3]);
      chk("p2wid",    p2wid,           act[4]);
      chk("cp",       32'(cp),         32'(act[5][7:0]));
      chk("p_bl",     32'(p_bl),       32'(act[6][7:0]));
      chk("p_bl_off", 32'(p_bl_off),   32'(act[7][15:0]));
      chk("pu",       32'(pu),         32'(act[8][0]));
      chk("bl",       32'(bl),         32'(act[8][1]));
      chk("commit",   32'(commit),     32'(m_commit));
      chk("tx_valid", 32'(tx_valid),   32'(m_txv));
      chk("tx_data",  32'(tx_data),    32'(m_txd));
      chk("err_cnt",  32'(err_cnt),    32'(m_err));
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b);
      @(negedge clk); rx_valid = 1'b1; rx_data = b;
      @(negedge clk); rx_valid = 1'b0;
   endtask

   task automatic idle_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); resetn = 1'b0; rx_valid = 1'b0;
      idle_n(2);
      resetn = 1'b1;
   endtask

   initial begin
      // reset state
      idle_n(2);
      resetn = 1'b1;
      chk("rst_per", per, 32'd201000);
      chk("rst_pu", 32'(pu), 32'd0);
      chk("rst_txv", 32'(tx_valid), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);

      // per write then commit
      send(8'h01); send(8'h00); send(8'h00); send(8'h03); send(8'hE8);
      chk("ack1_v", 32'(tx_valid), 32'd1);
      chk("ack1_d", 32'(tx_data), 32'h06);
      chk("per_pre", per, 32'd201000);
      send(8'h10);
      chk("per_post", per, 32'd1000);
      chk("commit_hi", 32'(commit), 32'd1);
      chk("ack2_d", 32'(tx_data), 32'h06);
      idle_n(1);
      chk("commit_lo", 32'(commit), 32'd0);

      // multi-field atomic commit
      send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h50);
      send(8'h08); send(8'h03);
      chk("p1_pre", p1wid, 32'd30);
      chk("pu_pre", 32'(pu), 32'd0);
      send(8'h10);
      chk("p1_post", p1wid, 32'd80);
      chk("pu_post", 32'(pu), 32'd1);
      chk("bl_post", 32'(bl), 32'd1);

      // unknown opcode
      do_reset();
      send(8'h7F);
      chk("nak_d", 32'(tx_data), 32'h15);
      chk("nak_err", 32'(err_cnt), 32'd1);
      send(8'h05); send(8'h07);
      chk("after_nak_d", 32'(tx_data), 32'h06);

      // timeout
      do_reset();
      send(8'h01); send(8'h00); send(8'h00);
      idle_n(T + 10);
      chk("to_txv", 32'(tx_valid), 32'd0);
      chk("to_err", 32'(err_cnt), 32'd1);
      send(8'h10);
      chk("to_ack", 32'(tx_data), 32'h06);
      chk("to_per", per, 32'd201000);

      // gap of T-1 idle cycles survives, T idle cycles aborts
      do_reset();
      send(8'h05); idle_n(T - 2); send(8'h09);
      chk("gapok_d", 32'(tx_data), 32'h06);
      chk("gapok_err", 32'(err_cnt), 32'd0);
      send(8'h10);
      chk("gapok_cp", 32'(cp), 32'd9);
      send(8'h05); idle_n(T - 1); send(8'h09);
      chk("gapto_err", 32'(err_cnt), 32'd2);
      chk("gapto_d", 32'(tx_data), 32'h15);

      // response overwrite and mid-frame reset
      do_reset();
      tx_ready = 1'b0;
      send(8'h05); send(8'h04);
      send(8'h10);
      chk("ovr_v", 32'(tx_valid), 32'd1);
      chk("ovr_d", 32'(tx_data), 32'h06);
      chk("ovr_err", 32'(err_cnt), 32'd1);
      chk("ovr_cp", 32'(cp), 32'd4);
      send(8'h03); send(8'h00);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("mrst_cp", 32'(cp), 32'd0);
      chk("mrst_per", per, 32'd201000);
      chk("mrst_txv", 32'(tx_valid), 32'd0);
      chk("mrst_err", 32'(err_cnt), 32'd0);
      tx_ready = 1'b1;

      // err_cnt saturation
      repeat (260) send(8'hFF);
      chk("sat_err", 32'(err_cnt), 32'd255);

      // randomized byte stream
      do_reset();
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 299) == 0) begin
            rx_valid = 1'b0;
            idle_n($urandom_range(T - 2, T + 2));
         end
         resetn   = ($urandom_range(0, 999) != 0);
         tx_ready = ($urandom_range(0, 3) != 0);
         rx_valid = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 7))
            0: rx_data = 8'($urandom);
            1: rx_data = 8'h10;
            default: rx_data = 8'($urandom_range(1, 8));
         endcase
      end
      @(negedge clk);
      rx_valid = 1'b0; resetn = 1'b1;
      idle_n(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
